// File: rtl/se_channel_scaler.sv
// -----------------------------------------------------------------------------
// se_channel_scaler
//
// Squeeze-and-Excitation output stage. Buffers one channel-major C x H x W
// feature-map frame, collects one attention scale per channel, then streams
// the frame back out with every element multiplied by its channel's scale
// (Q.FRAC_BITS, clamped to 1.0, rounded half up).
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_data/in_valid/in_ready        signed feature elements, channel-major
//   scale_data/scale_valid/scale_ready unsigned scales, scale i -> channel i
//   out_data/out_valid/out_ready     signed scaled elements, same order as input
//   frame_done               one-cycle pulse after the last output transfer
//   busy                     high while waiting for scales or draining
// -----------------------------------------------------------------------------
module se_channel_scaler #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 16,
  parameter int IN_HEIGHT  = 8,
  parameter int IN_WIDTH   = 8,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] scale_data,
  input  logic                  scale_valid,
  output logic                  scale_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int PIX   = IN_HEIGHT * IN_WIDTH;
  localparam int FRAME = CHANNELS * PIX;
  localparam int AW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int PW    = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SCW   = $clog2(CHANNELS + 1);
  localparam int PROD_W = 2 * DATA_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0]   ONE   = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic signed [PROD_W-1:0] ROUND = PROD_W'(1 << (FRAC_BITS - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WAIT_SCALE,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  // Write side
  logic [AW-1:0]  wr_addr;
  logic [SCW-1:0] scale_cnt;
  logic [DATA_WIDTH-1:0] scale_reg [CHANNELS];

  // Read side: rd_cnt counts issued RAM reads (one extra bit to reach FRAME),
  // rd_pix/rd_ch track the channel of the element being read without a divider.
  logic [AW:0]    rd_cnt;
  logic [PW-1:0]  rd_pix;
  logic [CW-1:0]  rd_ch;
  logic [CW-1:0]  s1_ch;
  logic           s1_valid;
  logic [AW-1:0]  out_cnt;

  logic [DATA_WIDTH-1:0] mem [FRAME];
  logic [DATA_WIDTH-1:0] rd_data;

  logic in_fire, scale_fire, out_fire;
  logic last_in, last_scale, all_scales, last_out;
  logic advance, issue;

  logic signed [DATA_WIDTH:0]  scale_s;
  logic signed [PROD_W-1:0]    prod;
  logic signed [PROD_W-1:0]    rounded;
  logic [DATA_WIDTH-1:0]       scaled;

  assign in_ready    = (state == S_FILL);
  assign scale_ready = ((state == S_FILL) || (state == S_WAIT_SCALE)) &&
                       (scale_cnt < SCW'(CHANNELS));

  assign in_fire    = in_valid && in_ready;
  assign scale_fire = scale_valid && scale_ready;
  assign out_fire   = out_valid && out_ready;

  assign last_in    = in_fire && (wr_addr == AW'(FRAME - 1));
  assign last_scale = scale_fire && (scale_cnt == SCW'(CHANNELS - 1));
  // A scale landing on the same edge as the last element still counts.
  assign all_scales = (scale_cnt == SCW'(CHANNELS)) || last_scale;
  assign last_out   = out_fire && (out_cnt == AW'(FRAME - 1));

  // The two-stage read pipeline (RAM read, multiply register) moves only when
  // the output register is empty or being consumed; otherwise everything,
  // including the RAM read enable, holds so nothing is dropped or repeated.
  assign advance = !out_valid || out_ready;
  assign issue   = (state == S_DRAIN) && (rd_cnt < (AW + 1)'(FRAME)) && advance;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       state_next = S_FILL;
      S_FILL:       if (last_in) state_next = all_scales ? S_DRAIN : S_WAIT_SCALE;
      S_WAIT_SCALE: if (last_scale) state_next = S_DRAIN;
      S_DRAIN:      if (last_out) state_next = S_FILL;
      default:      state_next = S_IDLE;
    endcase
  end

  // Signed element times unsigned scale (zero-extended to signed), rounded
  // half up by adding 0.5 LSB before the arithmetic shift. With scale <= 1.0
  // the shifted result always fits DATA_WIDTH bits.
  always_comb begin
    scale_s = signed'({1'b0, scale_reg[s1_ch]});
    prod    = PROD_W'($signed(rd_data)) * PROD_W'(scale_s);
    rounded = prod + ROUND;
    scaled  = DATA_WIDTH'(rounded >>> FRAC_BITS);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      wr_addr    <= '0;
      scale_cnt  <= '0;
      rd_cnt     <= '0;
      rd_pix     <= '0;
      rd_ch      <= '0;
      s1_ch      <= '0;
      s1_valid   <= 1'b0;
      out_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      for (int i = 0; i < CHANNELS; i++) scale_reg[i] <= '0;
    end else begin
      state      <= state_next;
      busy       <= (state_next == S_WAIT_SCALE) || (state_next == S_DRAIN);
      frame_done <= last_out;

      if (in_fire) wr_addr <= last_in ? '0 : wr_addr + 1'b1;

      if (scale_fire) begin
        scale_reg[scale_cnt[CW-1:0]] <= (scale_data > ONE) ? ONE : scale_data;
        scale_cnt <= scale_cnt + 1'b1;
      end

      if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
        s1_ch  <= rd_ch;
        if (rd_pix == PW'(PIX - 1)) begin
          rd_pix <= '0;
          rd_ch  <= rd_ch + 1'b1;
        end else begin
          rd_pix <= rd_pix + 1'b1;
        end
      end

      if (advance) begin
        s1_valid  <= issue;
        out_valid <= s1_valid;
        if (s1_valid) out_data <= scaled;
      end

      if (out_fire) out_cnt <= out_cnt + 1'b1;

      // Frame complete: the pipeline is already empty, so only counters and
      // the scale count need clearing before the next fill.
      if (last_out) begin
        scale_cnt <= '0;
        rd_cnt    <= '0;
        rd_pix    <= '0;
        rd_ch     <= '0;
        out_cnt   <= '0;
      end
    end
  end

  // NOTE: the frame buffer has no reset; every location is written during
  // fill before it is read, and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_addr] <= in_data;
    if (issue)   rd_data <= mem[rd_cnt[AW-1:0]];
  end

endmodule
